// File: rtl/por_pkg.sv
// Shared types and constants for the multi-channel power-on-reset sequencer.
//   por_state_t    : sequencer state encoding, also exported on state_o
//   BROWNOUT_CNT_W : width of the saturating brown-out event counter
package por_pkg;

    localparam int unsigned STATE_W        = 3;
    localparam int unsigned BROWNOUT_CNT_W = 4;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_STARTUP = 3'd1,
        ST_POR     = 3'd2,
        ST_SEQ     = 3'd3,
        ST_DONE    = 3'd4
    } por_state_t;

endpackage

// File: rtl/por_timer.sv
// One-shot up-counter used for both the startup and the POR intervals.
//   clk_i      : clock
//   rst_ni     : synchronous active-low reset
//   clear_i    : synchronous clear, wins over enable
//   enable_i   : count up by one
//   short_i    : select the short terminal count
//   count_o    : current count
//   tc_hit_o   : count is at the active terminal value
module por_timer #(
    parameter int unsigned W       = 9,
    parameter int unsigned SHORT_W = 5
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clear_i,
    input  logic         enable_i,
    input  logic         short_i,
    output logic [W-1:0] count_o,
    output logic         tc_hit_o
);

    localparam logic [W-1:0] LONG_TC  = '1;
    localparam logic [W-1:0] SHORT_TC = W'((64'd1 << SHORT_W) - 64'd1);

    logic [W-1:0] count_q;

    // Counter register; cleared by reset or by the owning state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            count_q <= '0;
        end else if (enable_i) begin
            count_q <= count_q + W'(1);
        end
    end

    // The long terminal always ends the interval, so switching to short mode
    // after the count has passed the short terminal never causes a wrap.
    assign tc_hit_o = (count_q == LONG_TC) || (short_i && (count_q == SHORT_TC));
    assign count_o  = count_q;

endmodule

// File: rtl/por_seq.sv
// Multi-channel power-on-reset sequencer. Waits for all power-good inputs,
// runs a startup one-shot then a POR one-shot, and releases the per-channel
// active-low resets in order with a programmable gap. Any power-good drop
// after leaving IDLE is a brown-out: resets re-assert and the sequence restarts.
//   osc_ck / rsb          : clock / synchronous active-low reset
//   pwup_filt             : per-channel power-good (asynchronous)
//   force_rc_osc          : force oscillator enable
//   force_short_oneshot   : short startup/POR intervals
//   keep_alive            : keep oscillator running in DONE
//   gap_cnt               : inter-channel gap minus one
//   otrip / otrip_decoded : trip select and its one-hot decode
//   osc_ena               : oscillator enable
//   por_unbuf             : high while in POR
//   rst_n_out             : sequenced active-low resets
//   brownout_evt / _cnt   : brown-out pulse and saturating count
//   state_o               : sequencer state
module por_seq
    import por_pkg::*;
#(
    parameter int unsigned NCH         = 4,
    parameter int unsigned ST_W        = 9,
    parameter int unsigned POR_W       = 15,
    parameter int unsigned ST_SHORT_W  = 5,
    parameter int unsigned POR_SHORT_W = 10,
    parameter int unsigned GAP_W       = 8,
    parameter int unsigned TRIP_W      = 3
) (
    input  logic                      osc_ck,
    input  logic                      rsb,
    input  logic [NCH-1:0]            pwup_filt,
    input  logic                      force_rc_osc,
    input  logic                      force_short_oneshot,
    input  logic                      keep_alive,
    input  logic [GAP_W-1:0]          gap_cnt,
    input  logic [TRIP_W-1:0]         otrip,
    output logic                      osc_ena,
    output logic [(1<<TRIP_W)-1:0]    otrip_decoded,
    output logic                      por_unbuf,
    output logic [NCH-1:0]            rst_n_out,
    output logic                      brownout_evt,
    output logic [BROWNOUT_CNT_W-1:0] brownout_cnt,
    output logic [STATE_W-1:0]        state_o
);

    localparam int unsigned IDX_W  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned TRIP_N = 1 << TRIP_W;

    logic [NCH-1:0]            sync1_q;
    logic [NCH-1:0]            pw_sync_q;
    logic                      all_up;

    por_state_t                state_q;
    logic [NCH-1:0]            rst_n_q;
    logic                      por_q;
    logic                      evt_q;
    logic [BROWNOUT_CNT_W-1:0] cnt_q;
    logic [GAP_W-1:0]          gap_q;
    logic [GAP_W-1:0]          gap_ctr_q;
    logic [IDX_W-1:0]          ch_idx_q;

    logic                      st_tc;
    logic                      por_tc;
    logic [ST_W-1:0]           st_count_unused;
    logic [POR_W-1:0]          por_count_unused;

    // Two-flop synchronizer per power-good bit.
    always_ff @(posedge osc_ck) begin
        if (!rsb) begin
            sync1_q   <= '0;
            pw_sync_q <= '0;
        end else begin
            sync1_q   <= pwup_filt;
            pw_sync_q <= sync1_q;
        end
    end

    assign all_up = &pw_sync_q;

    // Timers clear on their terminal edge and on a brown-out so they read
    // zero whenever their state is (re)entered.
    por_timer #(
        .W       (ST_W),
        .SHORT_W (ST_SHORT_W)
    ) u_st_timer (
        .clk_i    (osc_ck),
        .rst_ni   (rsb),
        .clear_i  ((state_q != ST_STARTUP) || !all_up || st_tc),
        .enable_i (state_q == ST_STARTUP),
        .short_i  (force_short_oneshot),
        .count_o  (st_count_unused),
        .tc_hit_o (st_tc)
    );

    por_timer #(
        .W       (POR_W),
        .SHORT_W (POR_SHORT_W)
    ) u_por_timer (
        .clk_i    (osc_ck),
        .rst_ni   (rsb),
        .clear_i  ((state_q != ST_POR) || !all_up || por_tc),
        .enable_i (state_q == ST_POR),
        .short_i  (force_short_oneshot),
        .count_o  (por_count_unused),
        .tc_hit_o (por_tc)
    );

    // Sequencer FSM with registered outputs; brown-out outranks every
    // other transition taken on the same edge.
    always_ff @(posedge osc_ck) begin
        if (!rsb) begin
            state_q   <= ST_IDLE;
            rst_n_q   <= '0;
            por_q     <= 1'b0;
            evt_q     <= 1'b0;
            cnt_q     <= '0;
            gap_q     <= '0;
            gap_ctr_q <= '0;
            ch_idx_q  <= '0;
        end else begin
            evt_q <= 1'b0;
            if ((state_q != ST_IDLE) && !all_up) begin
                state_q <= ST_IDLE;
                rst_n_q <= '0;
                por_q   <= 1'b0;
                evt_q   <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + BROWNOUT_CNT_W'(1);
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (all_up) begin
                            state_q <= ST_STARTUP;
                        end
                    end
                    ST_STARTUP: begin
                        if (st_tc) begin
                            state_q <= ST_POR;
                            por_q   <= 1'b1;
                        end
                    end
                    ST_POR: begin
                        if (por_tc) begin
                            por_q     <= 1'b0;
                            gap_q     <= gap_cnt;
                            gap_ctr_q <= '0;
                            ch_idx_q  <= IDX_W'(1);
                            if (NCH == 1) begin
                                state_q <= ST_DONE;
                                rst_n_q <= '1;
                            end else begin
                                state_q    <= ST_SEQ;
                                rst_n_q[0] <= 1'b1;
                            end
                        end
                    end
                    ST_SEQ: begin
                        // One channel per (gap+1) cycles; the last release ends SEQ.
                        if (gap_ctr_q == gap_q) begin
                            gap_ctr_q          <= '0;
                            rst_n_q[ch_idx_q]  <= 1'b1;
                            ch_idx_q           <= ch_idx_q + IDX_W'(1);
                            if (ch_idx_q == IDX_W'(NCH - 1)) begin
                                state_q <= ST_DONE;
                            end
                        end else begin
                            gap_ctr_q <= gap_ctr_q + GAP_W'(1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_DONE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        rst_n_q <= '0;
                        por_q   <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Oscillator may stop in DONE unless kept alive; brown-outs go unseen then.
    assign osc_ena       = force_rc_osc | ((|pw_sync_q) & ((state_q != ST_DONE) | keep_alive));
    assign otrip_decoded = TRIP_N'(1) << otrip;

    assign por_unbuf     = por_q;
    assign rst_n_out     = rst_n_q;
    assign brownout_evt  = evt_q;
    assign brownout_cnt  = cnt_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_por_seq.sv
// Self-checking bench for por_seq: a timeline-level reference model (phase
// plus elapsed cycles in phase) is stepped every edge and compared against
// all outputs, with directed timing checks and randomized episodes.
module tb_por_seq;

    localparam int NCH         = 4;
    localparam int ST_W        = 9;
    localparam int POR_W       = 15;
    localparam int ST_SHORT_W  = 5;
    localparam int POR_SHORT_W = 10;
    localparam int GAP_W       = 8;
    localparam int TRIP_W      = 3;

    logic                   osc_ck = 1'b0;
    logic                   rsb;
    logic [NCH-1:0]         pwup_filt;
    logic                   force_rc_osc;
    logic                   force_short_oneshot;
    logic                   keep_alive;
    logic [GAP_W-1:0]       gap_cnt;
    logic [TRIP_W-1:0]      otrip;
    logic                   osc_ena;
    logic [(1<<TRIP_W)-1:0] otrip_decoded;
    logic                   por_unbuf;
    logic [NCH-1:0]         rst_n_out;
    logic                   brownout_evt;
    logic [3:0]             brownout_cnt;
    logic [2:0]             state_o;

    always #5 osc_ck = ~osc_ck;

    por_seq #(
        .NCH(NCH), .ST_W(ST_W), .POR_W(POR_W), .ST_SHORT_W(ST_SHORT_W),
        .POR_SHORT_W(POR_SHORT_W), .GAP_W(GAP_W), .TRIP_W(TRIP_W)
    ) dut (
        .osc_ck              (osc_ck),
        .rsb                 (rsb),
        .pwup_filt           (pwup_filt),
        .force_rc_osc        (force_rc_osc),
        .force_short_oneshot (force_short_oneshot),
        .keep_alive          (keep_alive),
        .gap_cnt             (gap_cnt),
        .otrip               (otrip),
        .osc_ena             (osc_ena),
        .otrip_decoded       (otrip_decoded),
        .por_unbuf           (por_unbuf),
        .rst_n_out           (rst_n_out),
        .brownout_evt        (brownout_evt),
        .brownout_cnt        (brownout_cnt),
        .state_o             (state_o)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: phase 0..4 (IDLE..DONE), cycles elapsed in phase,
    // delayed copies of the power-good inputs, latched gap, event count.
    int             m_phase = 0;
    int             m_t     = 0;
    int             m_gap   = 0;
    int             m_cnt   = 0;
    bit             m_evt   = 0;
    logic [NCH-1:0] m_d1    = '0;
    logic [NCH-1:0] m_d2    = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit all_up;
        if (!rsb) begin
            m_phase = 0; m_t = 0; m_gap = 0; m_cnt = 0; m_evt = 0;
            m_d1 = '0; m_d2 = '0;
            return;
        end
        all_up = &m_d2;
        m_evt  = 0;
        if (m_phase != 0 && !all_up) begin
            m_phase = 0; m_t = 0; m_evt = 1;
            if (m_cnt < 15) m_cnt++;
        end else begin
            case (m_phase)
                0: if (all_up) begin m_phase = 1; m_t = 0; end
                1: begin
                    if (m_t == (2**ST_W) - 1 || (force_short_oneshot && m_t == (2**ST_SHORT_W) - 1)) begin
                        m_phase = 2; m_t = 0;
                    end else m_t++;
                end
                2: begin
                    if (m_t == (2**POR_W) - 1 || (force_short_oneshot && m_t == (2**POR_SHORT_W) - 1)) begin
                        m_gap   = int'(gap_cnt);
                        m_t     = 0;
                        m_phase = (NCH == 1) ? 4 : 3;
                    end else m_t++;
                end
                3: begin
                    m_t++;
                    if (m_t == (m_gap + 1) * (NCH - 1)) m_phase = 4;
                end
                default: ;
            endcase
        end
        m_d2 = m_d1;
        m_d1 = pwup_filt;
    endtask

    task automatic compare_all();
        logic [NCH-1:0] exp_rst;
        bit             exp_osc;
        for (int k = 0; k < NCH; k++)
            exp_rst[k] = (m_phase == 4) || (m_phase == 3 && (m_gap + 1) * k <= m_t);
        exp_osc = force_rc_osc | ((|m_d2) & ((m_phase != 4) | keep_alive));
        check("state",  32'(state_o),       32'(m_phase));
        check("rst_n",  32'(rst_n_out),     32'(exp_rst));
        check("por",    32'(por_unbuf),     32'(m_phase == 2));
        check("bo_evt", 32'(brownout_evt),  32'(m_evt));
        check("bo_cnt", 32'(brownout_cnt),  32'(m_cnt));
        check("osc",    32'(osc_ena),       32'(exp_osc));
        check("otrip",  32'(otrip_decoded), 32'(1) << otrip);
    endtask

    task automatic tick();
        @(posedge osc_ck);
        #1;
        cyc++;
        model_step();
        compare_all();
    endtask

    task automatic wait_phase(input int p, input int budget, input string tag);
        int n = 0;
        while (m_phase != p && n < budget) begin
            tick();
            n++;
        end
        if (m_phase != p) check(tag, 32'(m_phase), 32'(p));
    endtask

    task automatic do_reset();
        rsb = 1'b0;
        tick();
        tick();
        rsb = 1'b1;
    endtask

    initial begin
        int t0, rel, st_at, por_at, por_end, done_at;
        int rise_at[NCH];
        int glitch_left;
        logic [7:0] sweep;

        rsb = 1'b0; pwup_filt = '0; force_rc_osc = 1'b0; force_short_oneshot = 1'b1;
        keep_alive = 1'b0; gap_cnt = 8'd3; otrip = '0;
        do_reset();
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_rstn",  32'(rst_n_out), 32'd0);

        // Directed timeline: short mode, gap 3, all channels rise at cycle 0.
        tick();
        t0 = cyc;
        pwup_filt = '1;
        st_at = -1; por_at = -1; por_end = -1; done_at = -1;
        for (int k = 0; k < NCH; k++) rise_at[k] = -1;
        repeat (1100) begin
            tick();
            rel = cyc - t0;
            if (st_at < 0 && state_o == 3'd1) st_at = rel;
            if (por_at < 0 && por_unbuf) por_at = rel;
            if (por_at >= 0 && por_end < 0 && !por_unbuf) por_end = rel - 1;
            for (int k = 0; k < NCH; k++) if (rise_at[k] < 0 && rst_n_out[k]) rise_at[k] = rel;
            if (done_at < 0 && state_o == 3'd4) done_at = rel;
        end
        check("t_startup", 32'(st_at), 32'd3);
        check("t_por",     32'(por_at), 32'd35);
        check("t_por_end", 32'(por_end), 32'd1058);
        for (int k = 0; k < NCH; k++) check("t_rise", 32'(rise_at[k]), 32'(1059 + 4 * k));
        check("t_done",    32'(done_at), 32'd1071);
        check("osc_off_done", 32'(osc_ena), 32'd0);

        // Brown-out mid-POR, then restart.
        do_reset();
        pwup_filt = '1;
        wait_phase(2, 100, "to_por");
        repeat (100) tick();
        pwup_filt[2] = 1'b0;
        tick(); tick(); tick();
        check("bo_rstn",  32'(rst_n_out), 32'd0);
        check("bo_evt1",  32'(brownout_evt), 32'd1);
        check("bo_cnt1",  32'(brownout_cnt), 32'd1);
        check("bo_state", 32'(state_o), 32'd0);
        tick();
        check("bo_evt_once", 32'(brownout_evt), 32'd0);
        pwup_filt[2] = 1'b1;
        wait_phase(1, 5, "restart");

        // Brown-out coincides with the POR terminal edge.
        begin
            int n = 0;
            while (!(m_phase == 2 && m_t == (2**POR_SHORT_W) - 3) && n < 1200) begin
                tick(); n++;
            end
            check("reach_por_tc", 32'(m_t), 32'((2**POR_SHORT_W) - 3));
        end
        pwup_filt = '0;
        tick(); tick(); tick();
        check("bo_at_tc", 32'(state_o), 32'd0);
        check("bo_at_tc_rst", 32'(rst_n_out), 32'd0);

        // keep_alive holds the oscillator on in DONE.
        keep_alive = 1'b1;
        gap_cnt    = 8'd0;
        pwup_filt  = '1;
        wait_phase(4, 1200, "to_done_ka");
        repeat (3) tick();
        check("osc_keep", 32'(osc_ena), 32'd1);
        keep_alive = 1'b0;

        // Trip decoder sweep.
        for (int i = 0; i < 8; i++) begin
            otrip = TRIP_W'(i);
            #1;
            sweep = 8'h01 << i;
            check("otrip_sweep", 32'(otrip_decoded), 32'(sweep));
        end

        // Saturation after 17 brown-outs.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pwup_filt = '1;
            wait_phase(1, 10, "sat_up");
            tick(); tick();
            pwup_filt = '0;
            wait_phase(0, 10, "sat_down");
        end
        check("bo_sat", 32'(brownout_cnt), 32'd15);

        // Reset mid-SEQ.
        gap_cnt   = 8'd30;
        pwup_filt = '1;
        wait_phase(3, 1200, "to_seq");
        repeat (40) tick();
        rsb = 1'b0;
        tick();
        check("rsb_state", 32'(state_o), 32'd0);
        check("rsb_rstn",  32'(rst_n_out), 32'd0);
        check("rsb_por",   32'(por_unbuf), 32'd0);
        check("rsb_evt",   32'(brownout_evt), 32'd0);
        check("rsb_cnt",   32'(brownout_cnt), 32'd0);
        rsb = 1'b1;

        // Randomized episodes: glitches, mode flips in startup, resets.
        glitch_left = 0;
        for (int ep = 0; ep < 20; ep++) begin
            int len;
            keep_alive   = 1'($urandom_range(0, 1));
            force_rc_osc = ($urandom_range(0, 3) == 0);
            gap_cnt      = GAP_W'($urandom_range(0, 6));
            pwup_filt    = '1;
            len          = $urandom_range(5, 1300);
            repeat (len) begin
                tick();
                otrip = TRIP_W'($urandom);
                force_short_oneshot = (m_phase == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
                if ($urandom_range(0, 15) == 0) gap_cnt = GAP_W'($urandom_range(0, 7));
                rsb = ($urandom_range(0, 599) != 0);
                if (glitch_left > 0) begin
                    glitch_left--;
                    if (glitch_left == 0) pwup_filt = '1;
                end else if ($urandom_range(0, 249) == 0) begin
                    pwup_filt[$urandom_range(0, NCH - 1)] = 1'b0;
                    glitch_left = $urandom_range(1, 4);
                end
            end
            rsb = 1'b1;
            glitch_left = 0;
            force_short_oneshot = 1'b1;
            pwup_filt = '0;
            repeat (4) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
